// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern path: pattern modes,
// the packed colour record and the palette loaded at reset.
package vga_pkg;

    typedef enum logic [1:0] {
        VBARS   = 2'd0,
        HBARS   = 2'd1,
        CHECKER = 2'd2,
        SCROLL  = 2'd3
    } pattern_mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int DEFAULT_PAL_LEN = 8;

    // Channels are either 00 or FF, so only the top bit is needed to widen to any CW.
    localparam rgb_t DEFAULT_PAL [DEFAULT_PAL_LEN] = '{
        '{8'hFF, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h00},
        '{8'h00, 8'h00, 8'hFF},
        '{8'hFF, 8'hFF, 8'hFF},
        '{8'hFF, 8'hFF, 8'h00},
        '{8'h00, 8'hFF, 8'hFF},
        '{8'hFF, 8'h00, 8'hFF},
        '{8'h00, 8'h00, 8'h00}
    };

endpackage

// File: rtl/palette_regfile.sv
// NUM_BARS-entry colour palette: one synchronous write port, one combinational
// read port, entries return to the default palette on reset.
module palette_regfile
    import vga_pkg::*;
#(
    parameter int NUM_BARS = 4,
    parameter int CW       = 8,
    parameter int IW       = $clog2(NUM_BARS)
) (
    input  logic            clk_25,
    input  logic            TD_RESET_N,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [3*CW-1:0] wr_rgb,
    input  logic [IW-1:0]   rd_idx,
    output logic [3*CW-1:0] rd_rgb
);

    logic [3*CW-1:0] entry_reg [NUM_BARS];
    logic [3*CW-1:0] def_pal   [NUM_BARS];

    for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_default
        assign def_pal[gi] = {{CW{DEFAULT_PAL[gi % DEFAULT_PAL_LEN].r[7]}},
                              {CW{DEFAULT_PAL[gi % DEFAULT_PAL_LEN].g[7]}},
                              {CW{DEFAULT_PAL[gi % DEFAULT_PAL_LEN].b[7]}}};
    end

    always_ff @(posedge clk_25 or negedge TD_RESET_N) begin
        if (!TD_RESET_N) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                entry_reg[i] <= def_pal[i];
            end
        end else if (wr_en) begin
            entry_reg[wr_idx] <= wr_rgb;
        end
    end

    // Same-cycle read sees the pre-write entry.
    assign rd_rgb = entry_reg[rd_idx];

endmodule

// File: rtl/color_bar_gen.sv
// Test-pattern generator: maps timing-core coordinates to a palette index per
// pattern mode and registers the resulting colour one cycle later.
module color_bar_gen
    import vga_pkg::*;
#(
    parameter int HVID        = 640,
    parameter int VVID        = 480,
    parameter int NUM_BARS    = 4,
    parameter int CW          = 8,
    parameter int SCROLL_STEP = 4,
    localparam int IW         = $clog2(NUM_BARS)
) (
    input  logic          clk_25,
    input  logic          TD_RESET_N,
    input  logic [9:0]    horizontal_num,
    input  logic [9:0]    vertical_num,
    input  logic          frame_start,
    input  logic          load_enable,
    input  logic [IW-1:0] load_idx,
    input  logic [3*CW-1:0] load_rgb,
    input  logic          mode_wr,
    input  logic [1:0]    mode_sel,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);

    localparam int BW = HVID / NUM_BARS;
    localparam int BH = VVID / NUM_BARS;

    pattern_mode_t   pending_mode_reg, pending_mode_next;
    pattern_mode_t   active_mode_reg, active_mode_next;
    logic [9:0]      offset_reg, offset_next;
    logic [10:0]     offset_adv;
    logic [3*CW-1:0] rgb_reg, rgb_next;

    logic [10:0]     scroll_sum;
    logic [10:0]     scroll_x;
    logic            blank;
    logic [NUM_BARS-2:0] h_ge, v_ge, x_ge;
    logic [IW-1:0]   hbar, vbar, xbar, bar_idx;
    logic [3*CW-1:0] pal_rgb;

    function automatic logic [IW-1:0] bar_count(input logic [NUM_BARS-2:0] ge);
        logic [IW-1:0] n;
        n = '0;
        for (int k = 0; k < NUM_BARS - 1; k++) begin
            if (ge[k]) n = IW'(k + 1);
        end
        return n;
    endfunction

    always_comb begin
        pending_mode_next = pending_mode_reg;
        active_mode_next  = active_mode_reg;
        offset_next       = offset_reg;
        offset_adv        = {1'b0, offset_reg} + 11'(SCROLL_STEP);
        if (frame_start) begin
            active_mode_next = pending_mode_reg;
            if (pending_mode_reg == SCROLL) begin
                offset_next = (offset_adv >= 11'(HVID)) ? 10'(offset_adv - 11'(HVID))
                                                        : offset_adv[9:0];
            end else begin
                offset_next = '0;
            end
        end
        if (mode_wr) begin
            pending_mode_next = pattern_mode_t'(mode_sel);
        end
    end

    // The pixel arriving with frame_start already belongs to the new frame,
    // so it is coloured with the freshly committed mode and offset.
    assign scroll_sum = {1'b0, horizontal_num} + {1'b0, offset_next};
    assign scroll_x   = (scroll_sum >= 11'(HVID)) ? scroll_sum - 11'(HVID) : scroll_sum;

    for (genvar gi = 1; gi < NUM_BARS; gi++) begin : g_thresh
        assign h_ge[gi-1] = {1'b0, horizontal_num} >= 11'(gi * BW);
        assign v_ge[gi-1] = {1'b0, vertical_num}   >= 11'(gi * BH);
        assign x_ge[gi-1] = scroll_x               >= 11'(gi * BW);
    end

    assign hbar = bar_count(h_ge);
    assign vbar = bar_count(v_ge);
    assign xbar = bar_count(x_ge);

    always_comb begin
        bar_idx = hbar;
        case (active_mode_next)
            VBARS:   bar_idx = hbar;
            HBARS:   bar_idx = vbar;
            CHECKER: bar_idx = hbar + vbar;
            SCROLL:  bar_idx = xbar;
            default: bar_idx = hbar;
        endcase
    end

    palette_regfile #(
        .NUM_BARS (NUM_BARS),
        .CW       (CW),
        .IW       (IW)
    ) u_palette (
        .clk_25     (clk_25),
        .TD_RESET_N (TD_RESET_N),
        .wr_en      (load_enable),
        .wr_idx     (load_idx),
        .wr_rgb     (load_rgb),
        .rd_idx     (bar_idx),
        .rd_rgb     (pal_rgb)
    );

    assign blank    = ({1'b0, horizontal_num} >= 11'(HVID)) || ({1'b0, vertical_num} >= 11'(VVID));
    assign rgb_next = blank ? '0 : pal_rgb;

    always_ff @(posedge clk_25 or negedge TD_RESET_N) begin
        if (!TD_RESET_N) begin
            pending_mode_reg <= VBARS;
            active_mode_reg  <= VBARS;
            offset_reg       <= '0;
            rgb_reg          <= '0;
        end else begin
            pending_mode_reg <= pending_mode_next;
            active_mode_reg  <= active_mode_next;
            offset_reg       <= offset_next;
            rgb_reg          <= rgb_next;
        end
    end

    assign red   = rgb_reg[3*CW-1 -: CW];
    assign green = rgb_reg[2*CW-1 -: CW];
    assign blue  = rgb_reg[CW-1   -: CW];

endmodule
